// File: rtl/terrain_crater.sv
// ---------------------------------------------------------------------------
// terrain_crater
//
// Carves a circular crater into the terrain column store. On a start request
// it walks every column covered by the circle. For each column it finds the
// half-height h of the circle at that column, reads the stored 512-bit column
// mask, clears rows cy-h..cy+h (clipped to the screen) and writes the column
// back. Bits are only ever cleared, never set.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        crater request, sampled only while idle
//   impact_x     crater centre column cx (10 bits)
//   impact_y     crater centre row cy (9 bits)
//   radius       crater radius r, 0..31
//   busy         high whenever a crater is in progress
//   done         one-cycle pulse when a crater completes
//   read_addr    store read column (0 while not reading)
//   terrain_out  store read data, valid one cycle after read_addr
//   we           store write enable
//   write_addr   store write column
//   terrain_in   store write data
// ---------------------------------------------------------------------------
module terrain_crater (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [9:0]   impact_x,
    input  logic [8:0]   impact_y,
    input  logic [4:0]   radius,
    output logic         busy,
    output logic         done,
    output logic [9:0]   read_addr,
    input  logic [511:0] terrain_out,
    output logic         we,
    output logic [9:0]   write_addr,
    output logic [511:0] terrain_in
);

    localparam int          NCOLS   = 640;
    localparam int          DEPTH   = 512;
    localparam logic [9:0]  NCOLS_W = 10'(NCOLS);
    localparam logic [10:0] COL_MAX = 11'(NCOLS - 1);
    localparam logic [8:0]  ROW_MAX = 9'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cx_q, cx_d;
    logic [8:0] cy_q, cy_d;
    logic [4:0] r_q, r_d;
    logic [9:0] x_q, x_d;
    logic [9:0] x_hi_q, x_hi_d;
    logic [4:0] h_q, h_d;

    // -----------------------------------------------------------------------
    // Column span of a new crater, computed from the raw inputs in IDLE.
    // -----------------------------------------------------------------------
    logic signed [10:0] col_lo_s;
    logic        [10:0] col_hi_u;
    logic        [9:0]  col_lo;
    logic        [9:0]  col_hi;

    assign col_lo_s = $signed({1'b0, impact_x}) - $signed({6'd0, radius});
    assign col_hi_u = {1'b0, impact_x} + {6'd0, radius};
    assign col_lo   = col_lo_s[10] ? 10'd0 : col_lo_s[9:0];
    assign col_hi   = (col_hi_u > COL_MAX) ? COL_MAX[9:0] : col_hi_u[9:0];

    // -----------------------------------------------------------------------
    // Circle test for the current column. x never leaves cx-r..cx+r, so the
    // true distance fits in 5 bits; the low 5 bits of the difference taken in
    // the right direction give it exactly (modulo-32 arithmetic is exact here).
    // -----------------------------------------------------------------------
    logic [4:0]  dx;
    logic [11:0] h_sq;
    logic [11:0] dx_sq;
    logic [11:0] r_sq;
    logic        outside;

    assign dx      = (x_q >= cx_q) ? (x_q[4:0] - cx_q[4:0]) : (cx_q[4:0] - x_q[4:0]);
    assign h_sq    = {7'd0, h_q} * {7'd0, h_q};
    assign dx_sq   = {7'd0, dx}  * {7'd0, dx};
    assign r_sq    = {7'd0, r_q} * {7'd0, r_q};
    assign outside = (h_sq + dx_sq) > r_sq;

    // -----------------------------------------------------------------------
    // Row span to clear in the current column, clipped to 0..DEPTH-1.
    // -----------------------------------------------------------------------
    logic signed [9:0]       row_lo_s;
    logic        [9:0]       row_hi_u;
    logic        [8:0]       row_lo;
    logic        [8:0]       row_hi;
    logic        [DEPTH-1:0] clear_mask;

    assign row_lo_s   = $signed({1'b0, cy_q}) - $signed({5'd0, h_q});
    assign row_hi_u   = {1'b0, cy_q} + {5'd0, h_q};
    assign row_lo     = row_lo_s[9] ? 9'd0 : row_lo_s[8:0];
    assign row_hi     = row_hi_u[9] ? ROW_MAX : row_hi_u[8:0];
    // Ones from row_lo upward ANDed with ones from row_hi downward.
    assign clear_mask = ({DEPTH{1'b1}} << row_lo) & ({DEPTH{1'b1}} >> (ROW_MAX - row_hi));

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        x_d     = x_q;
        x_hi_d  = x_hi_q;
        h_d     = h_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d    = impact_x;
                    cy_d    = impact_y;
                    r_d     = radius;
                    x_d     = col_lo;
                    x_hi_d  = col_hi;
                    h_d     = radius;
                    // A centre off the right edge carves nothing at all.
                    state_d = (impact_x >= NCOLS_W) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                // h shrinks until (h, dx) lies on or inside the circle; h = 0
                // always qualifies because dx <= r, so h never underflows.
                if (outside) begin
                    h_d = h_q - 5'd1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (x_q == x_hi_q) begin
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q + 10'd1;
                    h_d     = r_q;
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!reset_n) begin
            state_q <= S_IDLE;
            // NOTE: the datapath registers are only meaningful outside IDLE,
            // but they are cleared too so the whole block starts from a
            // known value in simulation.
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            x_q     <= '0;
            x_hi_q  <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            x_q     <= x_d;
            x_hi_q  <= x_hi_d;
            h_q     <= h_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state and datapath registers.
    // -----------------------------------------------------------------------
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign we         = (state_q == S_WRITE);
    assign read_addr  = (state_q == S_READ || state_q == S_WAIT) ? x_q : 10'd0;
    assign write_addr = (state_q == S_WRITE) ? x_q : 10'd0;
    assign terrain_in = (state_q == S_WRITE) ? (terrain_out & ~clear_mask) : '0;

endmodule

// File: tb/tb_terrain_crater.sv
// ---------------------------------------------------------------------------
// tb_terrain_crater
//
// Drives directed craters into terrain_crater connected to a behavioural
// column store. Each expected write (column and data, derived from
// hand-computed row ranges) is queued when the crater is issued; a monitor
// pops and compares on every write-enable cycle.
// ---------------------------------------------------------------------------
module tb_terrain_crater;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [9:0]   impact_x;
    logic [8:0]   impact_y;
    logic [4:0]   radius;
    logic         busy;
    logic         done;
    logic [9:0]   read_addr;
    logic [511:0] terrain_out;
    logic         we;
    logic [9:0]   write_addr;
    logic [511:0] terrain_in;

    terrain_crater dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .impact_x    (impact_x),
        .impact_y    (impact_y),
        .radius      (radius),
        .busy        (busy),
        .done        (done),
        .read_addr   (read_addr),
        .terrain_out (terrain_out),
        .we          (we),
        .write_addr  (write_addr),
        .terrain_in  (terrain_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural store: 1-cycle synchronous read, write committed at edge.
    logic [511:0] store_mem [0:639];
    logic         fill;

    always @(posedge clk) begin
        terrain_out <= store_mem[read_addr];
        if (fill) begin
            for (int c = 0; c < 640; c++) store_mem[c] <= '1;
        end else if (we) begin
            store_mem[write_addr] <= terrain_in;
        end
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int checks;
    int passes;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, want);
    endtask

    typedef struct {
        logic [9:0]   addr;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   last_we_cyc;

    // All-ground column with rows lo..hi turned to air.
    function automatic logic [511:0] exp_col(input int lo, input int hi);
        logic [511:0] v;
        v = '1;
        for (int i = lo; i <= hi; i++) v[i] = 1'b0;
        return v;
    endfunction

    task automatic push_exp(input int addr, input int lo, input int hi);
        exp_t e;
        e.addr = 10'(addr);
        e.data = exp_col(lo, hi);
        exp_q.push_back(e);
    endtask

    // Monitor: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0d want no write", write_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_addr", 512'(write_addr), 512'(e.addr));
                check("write_data", terrain_in, e.data);
            end
        end
    end

    task automatic fill_store();
        @(negedge clk);
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
    endtask

    // Issues one crater and waits (bounded) for done. exp_lat < 0 skips the
    // done-latency comparison; pulse_again fires a second start mid-crater
    // with different coordinates that must be ignored.
    task automatic run_crater(input int cx, input int cy, input int r,
                              input int exp_lat, input bit pulse_again,
                              output int start_cyc);
        bit got_done;
        int done_cyc;
        @(negedge clk);
        impact_x = 10'(cx);
        impact_y = 9'(cy);
        radius   = 5'(r);
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", 512'(busy), 512'(1));
        got_done = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 3000 && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end else begin
                if (pulse_again && i == 2) begin
                    start    = 1'b1;
                    impact_x = 10'd300;
                    impact_y = 9'd300;
                    radius   = 5'd5;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", 512'(got_done), 512'(1));
        if (exp_lat >= 0) check("done_latency", 512'(done_cyc - start_cyc), 512'(exp_lat));
        @(negedge clk);
        check("busy_after_done", 512'(busy), 512'(0));
        check("done_one_cycle", 512'(done), 512'(0));
        check("all_writes_seen", 512'(exp_q.size()), 512'(0));
    endtask

    int  sc;
    bit  found;
    bit  saw_done;

    initial begin
        checks      = 0;
        passes      = 0;
        cyc         = 0;
        last_we_cyc = 0;
        reset_n     = 1'b0;
        start       = 1'b1;
        fill        = 1'b1;
        impact_x    = 10'd5;
        impact_y    = 9'd5;
        radius      = 5'd3;

        // Reset held 3 cycles with start high: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy",       512'(busy),       512'(0));
            check("rst_done",       512'(done),       512'(0));
            check("rst_we",         512'(we),         512'(0));
            check("rst_read_addr",  512'(read_addr),  512'(0));
            check("rst_write_addr", 512'(write_addr), 512'(0));
            check("rst_terrain_in", terrain_in,       512'(0));
        end
        reset_n = 1'b1;
        start   = 1'b0;
        fill    = 1'b0;
        @(negedge clk);
        check("idle_busy", 512'(busy), 512'(0));

        // Single bit: r = 0 clears only row 200 of column 100.
        push_exp(100, 200, 200);
        run_crater(100, 200, 0, 4, 1'b0, sc);
        check("single_we_cycle", 512'(last_we_cyc - sc), 512'(3));
        check("single_col100", store_mem[100], exp_col(200, 200));
        check("single_col101", store_mem[101], '1);

        // r = 3 at (10,20).
        fill_store();
        push_exp(7, 20, 20);
        push_exp(8, 18, 22);
        push_exp(9, 18, 22);
        push_exp(10, 17, 23);
        push_exp(11, 18, 22);
        push_exp(12, 18, 22);
        push_exp(13, 20, 20);
        run_crater(10, 20, 3, -1, 1'b0, sc);

        // Clipped at column 0 and row 0.
        fill_store();
        push_exp(0, 0, 5);
        push_exp(1, 0, 6);
        push_exp(2, 0, 5);
        push_exp(3, 0, 5);
        push_exp(4, 0, 4);
        push_exp(5, 2, 2);
        run_crater(1, 2, 4, -1, 1'b0, sc);
        check("clip_col1023", store_mem[639], '1);

        // Clipped at the bottom row 511.
        fill_store();
        push_exp(318, 510, 510);
        push_exp(319, 509, 511);
        push_exp(320, 508, 511);
        push_exp(321, 509, 511);
        push_exp(322, 510, 510);
        run_crater(320, 510, 2, -1, 1'b0, sc);

        // Right edge.
        fill_store();
        push_exp(634, 100, 100);
        push_exp(635, 97, 103);
        push_exp(636, 96, 104);
        push_exp(637, 96, 104);
        push_exp(638, 96, 104);
        push_exp(639, 95, 105);
        run_crater(639, 100, 5, -1, 1'b0, sc);
        check("edge_col0", store_mem[0], '1);

        // Centre off screen: no writes, done right away.
        fill_store();
        run_crater(700, 100, 5, 0, 1'b0, sc);

        // Second start while busy, with different inputs, is ignored.
        fill_store();
        push_exp(49, 60, 60);
        push_exp(50, 59, 61);
        push_exp(51, 60, 60);
        run_crater(50, 60, 1, -1, 1'b1, sc);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) saw_done = 1'b1;
        end
        check("no_restart", 512'(saw_done), 512'(0));
        check("ignored_col300", store_mem[300], '1);

        // Reset during the WAIT of the third column.
        fill_store();
        push_exp(7, 20, 20);
        push_exp(8, 18, 22);
        @(negedge clk);
        impact_x = 10'd10;
        impact_y = 9'd20;
        radius   = 5'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (read_addr == 10'd9) found = 1'b1;
            else @(negedge clk);
        end
        check("reached_col9", 512'(found), 512'(1));
        @(negedge clk);
        check("wait_read_addr", 512'(read_addr), 512'(9));
        check("wait_we", 512'(we), 512'(0));
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_we", 512'(we), 512'(0));
        check("midrst_read_addr", 512'(read_addr), 512'(0));
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_quiet", 512'(saw_done), 512'(0));
        check("midrst_queue", 512'(exp_q.size()), 512'(0));
        check("midrst_col7", store_mem[7], exp_col(20, 20));
        check("midrst_col8", store_mem[8], exp_col(18, 22));
        check("midrst_col9", store_mem[9], '1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/terrain_crater.md
# terrain_crater

Crater carver sitting directly on the write/read side of the terrain column store. On a `start` request it walks every terrain column covered by a circular impact, reads the stored 512-bit column mask, clears the bits inside the circle, and writes the column back. The result is air (bit = 0) where there was ground (bit = 1). It drives the store's `read_addr`, `we`, `write_addr` and `terrain_in`, and consumes the store's `terrain_out`.

## Interface
- `NCOLS`, 640, number of terrain columns; valid column addresses are 0..NCOLS-1.
- `DEPTH`, 512, bits per column mask; bit index = screen row, 1 = ground, 0 = air.
- `clk` input 1: the single clock; every register is clocked on its rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `start` input 1: request; sampled only in IDLE.
- `impact_x` input 10: crater centre column `cx`.
- `impact_y` input 9: crater centre row `cy`.
- `radius` input 5: crater radius `r`, 0..31.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a crater completes.
- `read_addr` output 10: column address to the store.
- `terrain_out` input 512: store read data, valid one cycle after `read_addr`.
- `we` output 1: store write enable.
- `write_addr` output 10: store write column.
- `terrain_in` output 512: store write data.

## Operation
- States: IDLE, CALC, READ, WAIT, WRITE, DONE. Outputs are decoded from registered state and datapath registers.
- **IDLE**
  - `busy`=0.
  - On `start`, latch `cx`, `cy`, `r`.
  - Compute, as 11-bit signed values, `x_lo` = max(cx−r, 0) and `x_hi` = min(cx+r, NCOLS−1).
  - Set `x` = `x_lo` and `h` = `r`.
  - If `cx` ≥ NCOLS, go to DONE with no store access. Otherwise go to CALC.
- **CALC**
  - `dx` = |x−cx|.
  - If h²+dx² > r², then `h`←h−1 and stay in CALC.
  - Otherwise go to READ.
  - Terminates because dx ≤ r.
  - Width rules: squares are 12-bit unsigned (max 961+961 = 1922), with no truncation.
- **READ**: `read_addr`=x. Go to WAIT.
- **WAIT**: `read_addr`=x held; `terrain_out` becomes valid. Go to WRITE.
- **WRITE**
  - `we`=1, `write_addr`=x.
  - `terrain_in` = `terrain_out` & ~mask, where mask bit i = 1 iff lo ≤ i ≤ hi.
  - lo = max(cy−h, 0) and hi = min(cy+h, DEPTH−1).
  - Air bits are never set.
  - If x == `x_hi`, go to DONE. Otherwise `x`←x+1, `h`←r, and go to CALC.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor restarting the crater.
- Latched `cx`, `cy`, `r` are stable for the whole crater; input changes while busy have no effect.
- `r`=0 clears only bit `cy` of column `cx`.
- Column addresses never wrap: no access below 0 or above NCOLS−1.
- `read_addr` is 0 in IDLE and DONE. `we` is 0 in every state except WRITE.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `we`=0, `read_addr`=0, `write_addr`=0, `terrain_in`=0.
- Reset mid-crater: reset_n sampled low at an edge forces IDLE from that edge on.
  - No further `we`, no `done`.
  - Columns already written stay written.
- Latency: `start` sampled at edge 0 enters CALC at edge 0.
- Per column: (r−h_final+1) CALC cycles + 1 READ + 1 WAIT + 1 WRITE.
- `done` is high in the cycle after the last WRITE cycle. `busy` drops the cycle after `done`.
- Store assumptions:
  - Synchronous read with 1-cycle latency.
  - Write in the WRITE cycle is committed at the next edge.
  - No other writer to the store while `busy`.

## Test plan
- **Reset**: hold reset_n=0 for 3 cycles with `start`=1.
  - Required: all outputs 0, `busy`=0, no `we`.
- **Single bit**: all-ground store, start (100,200,r=0).
  - Required: CALC 1 cycle.
  - `we` in exactly one cycle, 4th cycle after start, addr 100, bit 200 cleared, others 1.
  - `done` next cycle.
- **r=3 at (10,20)**:
  - Required: writes to columns 7..13 in ascending order, one `we` each.
  - Col 10 clears bits 17..23; cols 8, 9, 11, 12 clear 18..22; cols 7 and 13 clear bit 20 only.
- **Clipping**: (1,2,r=4).
  - Required: columns 0..5 only; column 1 clears bits 0..6; no write to address 1023 or any wrapped address.
- **Right edge and out of range**:
  - (639,100,r=5) → writes only columns 634..639.
  - (700,100,r=5) → no `we`, `done` one cycle after start.
- **Protocol**:
  - Pulse `start` again while busy: ignored, exactly one crater written.
  - Assert reset_n=0 during the WAIT of the 3rd column: no further `we`, `busy`=0 after that edge, columns 1–2 keep their edits.
